// File: rtl/vga_timing_rx.sv
// vga_timing_rx: recovers pixel coordinates, line/frame measurements and raster lock from hsync/vsync/valid.
// Defining VGA_TIMING_RX_ERRCNT_EN adds a saturating err_count of timing_err pulses.
module vga_timing_rx #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       pclk,
  input  logic       reset,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       valid,
  output logic [9:0] px_x,
  output logic [9:0] px_y,
  output logic       px_valid,
  output logic [9:0] line_len,
  output logic [9:0] frame_lines,
  output logic       locked,
  output logic       frame_start,
  output logic       timing_err
`ifdef VGA_TIMING_RX_ERRCNT_EN
  ,
  output logic [7:0] err_count
`endif
);
  localparam logic [1:0] SEARCH  = 2'd0;
  localparam logic [1:0] MEASURE = 2'd1;
  localparam logic [1:0] LOCK    = 2'd2;
  logic s_h, s_v, s_de, p_h, p_v, p_de;
  logic [9:0] hc, vc, col, col_b;
  logic [1:0] st, st_nx;
  logic [3:0] good, good_nx;
  logic h_seen, sticky;
  logic hfall, vfall, defall, wd, line_mis, de_mis, frame_bad, err;
  always_comb begin
    hfall = p_h & ~s_h;
    vfall = p_v & ~s_v;
    defall = p_de & ~s_de;
    wd = (&hc) & ~hfall;
    line_mis = hfall & h_seen & (({1'b0, hc} + 11'd1) != 11'(H_TOTAL));
    de_mis = defall & (col != 10'(H_ACTIVE));
    frame_bad = sticky | line_mis | de_mis | ((px_y + 10'(defall)) != 10'(V_ACTIVE)) |
                (({1'b0, vc} + 11'd1) != 11'(V_TOTAL));
    col_b = hfall ? '0 : col;
    err = (st == LOCK) & (wd | line_mis | (vfall & frame_bad));
    st_nx = st;
    good_nx = good;
    if (wd) begin
      st_nx = SEARCH;
      good_nx = '0;
    end else if (st == SEARCH) begin
      st_nx = vfall ? MEASURE : SEARCH;
      good_nx = '0;
    end else if (st == LOCK) begin
      st_nx = (line_mis | (vfall & frame_bad)) ? MEASURE : LOCK;
      good_nx = '0;
    end else if (vfall) begin
      good_nx = frame_bad ? '0 : good + 4'd1;
      if (!frame_bad && (good + 4'd1) == 4'(LOCK_FRAMES)) begin
        st_nx = LOCK;
        good_nx = '0;
      end
    end
  end
  always_ff @(posedge pclk or posedge reset)
    if (reset) begin
      {s_h, s_v, s_de} <= 3'b110;
      {p_h, p_v, p_de} <= 3'b110;
      hc <= '0;
      vc <= '0;
      col <= '0;
      st <= SEARCH;
      good <= '0;
      h_seen <= 1'b0;
      sticky <= 1'b0;
      px_x <= '0;
      px_y <= '0;
      px_valid <= 1'b0;
      line_len <= '0;
      frame_lines <= '0;
      locked <= 1'b0;
      frame_start <= 1'b0;
      timing_err <= 1'b0;
`ifdef VGA_TIMING_RX_ERRCNT_EN
      err_count <= '0;
`endif
    end else begin
      {s_h, s_v, s_de} <= {hsync, vsync, valid};
      {p_h, p_v, p_de} <= {s_h, s_v, s_de};
      hc <= hfall ? '0 : (&hc) ? hc : hc + 10'd1;
      vc <= vfall ? '0 : vc + 10'(hfall);
      col <= col_b + 10'(s_de);
      h_seen <= wd ? 1'b0 : h_seen | hfall;
      sticky <= ~vfall & (sticky | line_mis | de_mis);
      st <= st_nx;
      good <= good_nx;
      line_len <= (hfall & h_seen) ? hc + 10'd1 : line_len;
      frame_lines <= vfall ? vc + 10'd1 : frame_lines;
      px_x <= s_de ? col_b : px_x;
      px_y <= vfall ? '0 : px_y + 10'(defall);
      px_valid <= s_de;
      locked <= st_nx == LOCK;
      frame_start <= vfall & (st == LOCK);
      timing_err <= err;
`ifdef VGA_TIMING_RX_ERRCNT_EN
      err_count <= (err & ~&err_count) ? err_count + 8'd1 : err_count;
`endif
    end
endmodule

// File: tb/tb_vga_timing_rx.sv
// tb_vga_timing_rx: random-perturbed raster stimulus with a line/frame-level reference model and scoreboard monitor.
module tb_vga_timing_rx;
  localparam int HT = 40, HA = 24, VT = 20, VA = 12, LF = 2;
  logic pclk = 0, reset = 1, hsync = 1, vsync = 1, valid = 0;
  logic [9:0] px_x, px_y, line_len, frame_lines;
  logic px_valid, locked, frame_start, timing_err;
`ifdef VGA_TIMING_RX_ERRCNT_EN
  logic [7:0] err_count;
`endif
  vga_timing_rx #(.H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA), .LOCK_FRAMES(LF)) dut (
    .pclk(pclk), .reset(reset), .hsync(hsync), .vsync(vsync), .valid(valid),
    .px_x(px_x), .px_y(px_y), .px_valid(px_valid), .line_len(line_len),
    .frame_lines(frame_lines), .locked(locked), .frame_start(frame_start), .timing_err(timing_err)
`ifdef VGA_TIMING_RX_ERRCNT_EN
    , .err_count(err_count)
`endif
  );
  always #20 pclk = ~pclk;
  typedef struct {int c; int x; int y;} pix_t;
  typedef struct {int c; int k; int v;} chk_t;
  pix_t pq[$];
  chk_t cq[$];
  int errq[$], fsq[$];
  int cyc = 0, nchk = 0, npass = 0;
  int mst, good, nlines, nact, last_len, last_start, nerr;
  bit hseen, fbad;
  always @(posedge pclk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act == exp) npass++;
    else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
  endtask
  task automatic model_init();
    mst = 0; good = 0; nlines = 0; nact = 0; last_len = 0; last_start = 0;
    nerr = 0; hseen = 0; fbad = 0;
  endtask
  // Evaluates the closing line (and frame, on a frame start) against the nominal raster.
  task automatic line_start(input bit fs);
    int t;
    bit lmis, bad, e;
    t = cyc + 2;
    e = 0;
    last_start = cyc;
    lmis = hseen && last_len != HT;
    if (hseen) cq.push_back('{t, 1, last_len});
    if (fs) begin
      bad = fbad || lmis || nact != VA || nlines + 1 != VT;
      cq.push_back('{t, 2, nlines + 1});
      if (mst == 2) begin
        fsq.push_back(t);
        if (bad) begin e = 1; mst = 1; good = 0; end
      end else if (mst == 1) begin
        if (bad) good = 0;
        else if (good + 1 == LF) begin mst = 2; good = 0; end
        else good++;
      end else begin
        mst = 1; good = 0;
      end
      fbad = 0; nlines = 0; nact = 0;
    end else begin
      if (mst == 2 && lmis) begin e = 1; mst = 1; good = 0; end
      fbad |= lmis;
      nlines++;
    end
    hseen = 1;
    cq.push_back('{t, 0, int'(mst == 2)});
    if (e) begin errq.push_back(t); nerr++; end
  endtask
  task automatic line(input int len, input bit vs, input bit fs, input bit act, input int cut);
    for (int c = 0; c < cut; c++) begin
      @(negedge pclk);
      hsync = !(c < 4);
      vsync = !vs;
      valid = act && c >= 8 && c < 8 + HA;
      if (c == 0) line_start(fs);
      if (valid) pq.push_back('{cyc + 2, c - 8, nact});
    end
    last_len = len;
    if (act && cut == len) nact++;
  endtask
  task automatic frame(input int nl, input int stretch, input int ext, input int va);
    for (int l = 0; l < nl; l++)
      line(l == stretch ? HT + ext : HT, l < 2, l == 0, l >= 4 && l < 4 + va, l == stretch ? HT + ext : HT);
  endtask
  task automatic hold(input int n);
    int t;
    t = last_start + 1026;
    if (mst == 2) begin errq.push_back(t); nerr++; end
    cq.push_back('{t, 0, 0});
    mst = 0; good = 0; hseen = 0;
    repeat (n) begin
      @(negedge pclk);
      hsync = 1; vsync = 1; valid = 0;
    end
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_px_x"}, px_x, 0);
    chk({tag, "_px_y"}, px_y, 0);
    chk({tag, "_px_valid"}, px_valid, 0);
    chk({tag, "_line_len"}, line_len, 0);
    chk({tag, "_frame_lines"}, frame_lines, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_frame_start"}, frame_start, 0);
    chk({tag, "_timing_err"}, timing_err, 0);
`ifdef VGA_TIMING_RX_ERRCNT_EN
    chk({tag, "_err_count"}, err_count, 0);
`endif
  endtask
  pix_t p;
  chk_t q;
  bit ee, ef;
  always @(negedge pclk) if (!reset) begin
    if (px_valid) begin
      if (pq.size() == 0) chk("px_unexpected", 1, 0);
      else begin
        p = pq.pop_front();
        chk("px_latency", cyc, p.c);
        chk("px_x", px_x, p.x);
        chk("px_y", px_y, p.y);
      end
    end
    while (cq.size() > 0 && cq[0].c <= cyc) begin
      q = cq.pop_front();
      if (q.k == 0) chk("locked", locked, q.v);
      else if (q.k == 1) chk("line_len", line_len, q.v);
      else chk("frame_lines", frame_lines, q.v);
    end
    ee = errq.size() > 0 && errq[0] == cyc;
    if (ee || timing_err) chk("timing_err", timing_err, ee);
    if (ee) void'(errq.pop_front());
    ef = fsq.size() > 0 && fsq[0] == cyc;
    if (ef || frame_start) chk("frame_start", frame_start, ef);
    if (ef) void'(fsq.pop_front());
  end
  initial begin
    model_init();
    repeat (3) @(negedge pclk);
    check_zero("reset");
    reset = 0;
    repeat (4) frame(VT, -1, 0, VA);
    frame(VT, $urandom_range(1, VT - 1), $urandom_range(1, 3), VA);
    repeat (2) frame(VT, -1, 0, VA);
    frame(6, -1, 0, VA);
    hold($urandom_range(1050, 1200));
    frame(VT, -1, 0, VA);
    frame(VT, -1, 0, VA - 1);
    repeat (3) frame(VT, -1, 0, VA);
    frame(5, -1, 0, VA);
    line(HT, 0, 0, 1, $urandom_range(10, 30));
`ifdef VGA_TIMING_RX_ERRCNT_EN
    chk("err_count_before_reset", err_count, nerr);
`endif
    chk("locked_before_reset", locked, 1);
    #2;
    pq.delete(); cq.delete(); errq.delete(); fsq.delete();
    reset = 1; hsync = 1; vsync = 1; valid = 0;
    #1;
    check_zero("async_reset");
    repeat (3) @(negedge pclk);
    reset = 0;
    model_init();
    repeat (3) frame(VT, -1, 0, VA);
    line(HT, 1, 1, 0, HT);
    repeat (6) @(negedge pclk);
    chk("pix_queue_drained", pq.size(), 0);
    chk("chk_queue_drained", cq.size(), 0);
    chk("err_queue_drained", errq.size(), 0);
    chk("fs_queue_drained", fsq.size(), 0);
`ifdef VGA_TIMING_RX_ERRCNT_EN
    chk("err_count_end", err_count, nerr);
`endif
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
